video_fetch_sched: RTL and testbench
====================================

VIDEO_FETCH_SCHED -- requirements
Module: video_fetch_sched

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 5: number of video words fetched per frame.
REQ-002 SHALL have parameter READ_LAT, default 1: cycles from addr_B change to valid DataVideo.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: reset is synchronous and active-low.
REQ-005 SHALL have port vblank_start, input, 1: one-cycle pulse at start of vertical blanking that requests a frame fetch.
REQ-006 SHALL have port clr_overrun, input, 1: pulse that clears the overrun flag.
REQ-007 SHALL have port addr_B, output, 32: read address driven to the memory video port.
REQ-008 SHALL have port DataVideo, input, 32: read data from the memory video port.
REQ-009 SHALL have port snap_words, output, NUM_WORDS*32: frame snapshot; word k occupies bits [32k+31:32k].
REQ-010 SHALL have port snap_valid, output, 1: high once at least one complete snapshot is committed.
REQ-011 SHALL have port busy, output, 1: high while a fetch is in progress.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse in the cycle a new snapshot first appears on snap_words.
REQ-013 SHALL have port overrun, output, 1: sticky flag; a vblank_start arrived while busy.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, DRAIN, COMMIT.
REQ-015 IDLE: SHALL hold addr_B = VID_ADDR[0] (0x00006000) and busy = 0.
REQ-016 IDLE with vblank_start = 1: SHALL move to ISSUE; busy = 1 from the next cycle.
REQ-017 ISSUE: SHALL drive addr_B = VID_ADDR[i] in consecutive cycles, i = 0..NUM_WORDS-1, one address per cycle, no gaps.
REQ-018 Address table SHALL be 0x00006000, 0x00007000, 0x00008000, 0x00009000, 0x00010000 for indices 0..4.
REQ-019 Each DataVideo sample SHALL be captured into staging word i exactly READ_LAT cycles after VID_ADDR[i] is driven.
REQ-020 After the last address is issued, the FSM SHALL enter DRAIN and remain there READ_LAT cycles; addr_B SHALL hold the last address.
REQ-021 COMMIT: SHALL copy all staging words to snap_words in one cycle, set snap_valid = 1, pulse frame_done, and return to IDLE.
REQ-022 snap_words SHALL never show a mix of two frames; it changes only on COMMIT.
REQ-023 Latency SHALL be as follows: vblank_start at cycle t gives new snap_words and frame_done at cycle t + NUM_WORDS + READ_LAT + 2 (t+8 for the default parameters).
REQ-024 vblank_start while busy SHALL be ignored (no restart, no queueing) and SHALL set overrun.
REQ-025 clr_overrun SHALL clear overrun; if it coincides with a new overrun event, set SHALL win.
REQ-026 vblank_start in the COMMIT cycle SHALL count as busy: it is ignored and sets overrun.
REQ-027 The index counter SHALL be ceil(log2(NUM_WORDS)) bits and SHALL never exceed NUM_WORDS-1; no wrap-around reissue.

Reset
REQ-028 While reset = 0 at a clock edge, the block SHALL enter IDLE with: addr_B = 0x00006000; snap_words and staging = 0; snap_valid, busy, frame_done and overrun = 0.
REQ-029 Reset during ISSUE or DRAIN SHALL abort the fetch with no commit; in-flight DataVideo SHALL be discarded.
REQ-030 vblank_start in the first cycle after reset deassertion SHALL be accepted normally.

Structure
REQ-031 Package video_map_pkg SHALL hold the VID_ADDR table, the default NUM_WORDS, and the FSM state enum; the DataMemory address decode SHALL share the same table.
REQ-032 One sub-module, vid_capture_pipe, SHALL be used: a READ_LAT-deep valid/index shift pipeline producing capture enables for the staging words.
REQ-033 There SHALL be no combinational path from DataVideo to any output.

Verification
REQ-034 Memory model with words 0x11,0x22,0x33,0x44,0x55 and vblank_start pulse at t -> addr_B steps 6000,7000,8000,9000,10000 over t+1..t+5; frame_done at t+8; snap_words = {55,44,33,22,11}; snap_valid = 1.
REQ-035 Second vblank_start at t+3 -> overrun = 1; the fetch completes unchanged at t+8; no second fetch starts.
REQ-036 Memory contents changed to 0xAA.. during the fetch after word 2 is read -> snap_words holds old words 0-2 and new words 3-4; the previous snapshot stays stable until frame_done.
REQ-037 reset = 0 at t+4 -> no frame_done; snap_words = 0; busy = 0; addr_B = 0x6000 on the next cycle.
REQ-038 clr_overrun and an ignored vblank_start in the same cycle -> overrun stays 1; clr_overrun alone -> overrun = 0.
REQ-039 READ_LAT = 2 build -> frame_done at t+9 with correct word alignment.

Source files
------------

// File: rtl/video_map_pkg.sv
// Shared video memory map: fetch address table, default frame size and fetch FSM states.
// The DataMemory decode uses vid_addr_hit() so both sides share one table.
package video_map_pkg;

    localparam int VID_NUM_WORDS = 5;
    localparam int VID_TABLE_LEN = 5;

    localparam logic [31:0] VID_ADDR [VID_TABLE_LEN] = '{
        32'h0000_6000, 32'h0000_7000, 32'h0000_8000, 32'h0000_9000, 32'h0001_0000
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } vid_state_e;

    // Out-of-table indices fall back to the first entry.
    function automatic logic [31:0] vid_addr(input int idx);
        logic [31:0] a;
        a = VID_ADDR[0];
        for (int k = 0; k < VID_TABLE_LEN; k++) begin
            if (k == idx) a = VID_ADDR[k];
        end
        return a;
    endfunction

    function automatic logic vid_addr_hit(input logic [31:0] addr);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < VID_TABLE_LEN; k++) begin
            if (addr == VID_ADDR[k]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/vid_capture_pipe.sv
// Delays the issue valid/index by the memory read latency so each staging word
// is written in the cycle its read data is on DataVideo.
module vid_capture_pipe #(
    parameter int READ_LAT = 1,
    parameter int IW       = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [IW-1:0] in_idx,
    output logic          cap_valid,
    output logic [IW-1:0] cap_idx
);

    logic [READ_LAT-1:0]         vld_d, vld_q;
    logic [READ_LAT-1:0][IW-1:0] idx_d, idx_q;

    always_comb begin
        vld_d    = vld_q;
        idx_d    = idx_q;
        vld_d[0] = in_valid;
        idx_d[0] = in_idx;
        for (int s = 1; s < READ_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            idx_d[s] = idx_q[s-1];
        end
    end

    // Clearing on reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    assign cap_valid = vld_q[READ_LAT-1];
    assign cap_idx   = idx_q[READ_LAT-1];

endmodule

// File: rtl/video_fetch_sched.sv
// Per-frame video fetch: on vblank_start reads NUM_WORDS words from the video port
// into staging, then commits them to snap_words atomically.
module video_fetch_sched
    import video_map_pkg::*;
#(
    parameter int NUM_WORDS = VID_NUM_WORDS,
    parameter int READ_LAT  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    vblank_start,
    input  logic                    clr_overrun,
    output logic [31:0]             addr_B,
    input  logic [31:0]             DataVideo,
    output logic [NUM_WORDS*32-1:0] snap_words,
    output logic                    snap_valid,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int DW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int SW = NUM_WORDS * 32;
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_WORDS - 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(READ_LAT - 1);

    vid_state_e    state_d, state_q;
    logic [IW-1:0] idx_d, idx_q;
    logic [DW-1:0] drain_d, drain_q;
    logic [31:0]   addr_d, addr_q;
    logic [SW-1:0] stage_d, stage_q;
    logic [SW-1:0] snap_d, snap_q;
    logic          snap_valid_d, snap_valid_q;
    logic          busy_d, busy_q;
    logic          frame_done_d, frame_done_q;
    logic          overrun_d, overrun_q;
    logic          cap_valid;
    logic [IW-1:0] cap_idx;

    vid_capture_pipe #(.READ_LAT(READ_LAT), .IW(IW)) u_cap (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (state_q == ISSUE),
        .in_idx    (idx_q),
        .cap_valid (cap_valid),
        .cap_idx   (cap_idx)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        drain_d      = drain_q;
        stage_d      = stage_q;
        snap_d       = snap_q;
        snap_valid_d = snap_valid_q;
        frame_done_d = 1'b0;

        for (int k = 0; k < NUM_WORDS; k++) begin
            if (cap_valid && cap_idx == IW'(k)) stage_d[k*32 +: 32] = DataVideo;
        end

        case (state_q)
            IDLE: begin
                if (vblank_start) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                end
            end
            ISSUE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == '0) state_d = COMMIT;
                else               drain_d = drain_q - DW'(1);
            end
            COMMIT: begin
                snap_d       = stage_q;
                snap_valid_d = 1'b1;
                frame_done_d = 1'b1;
                state_d      = IDLE;
                idx_d        = '0;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        addr_d = vid_addr(int'(idx_d));

        // Any vblank outside IDLE (COMMIT included) is dropped and flagged; set beats clear.
        if (vblank_start && state_q != IDLE) overrun_d = 1'b1;
        else if (clr_overrun)                overrun_d = 1'b0;
        else                                 overrun_d = overrun_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            drain_q      <= '0;
            addr_q       <= VID_ADDR[0];
            stage_q      <= '0;
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            drain_q      <= drain_d;
            addr_q       <= addr_d;
            stage_q      <= stage_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign addr_B     = addr_q;
    assign snap_words = snap_q;
    assign snap_valid = snap_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_video_fetch_sched.sv
// Bench for video_fetch_sched: READ_LAT=1 and READ_LAT=2 instances share stimulus;
// a latency-aware memory model and frame-level reference feed a commit scoreboard.
module tb_video_fetch_sched;

    localparam int N  = 5;
    localparam int SW = N * 32;
    localparam logic [31:0] TB_ADDR [N] = '{
        32'h6000, 32'h7000, 32'h8000, 32'h9000, 32'h10000
    };

    typedef struct {
        logic [SW-1:0] words;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, vblank, clr;
    logic [31:0]   addr_b [2];
    logic [31:0]   dv     [2];
    logic [SW-1:0] snap   [2];
    logic          sv     [2];
    logic          busy   [2];
    logic          fdone  [2];
    logic          ovr_o  [2];

    video_fetch_sched #(.NUM_WORDS(N), .READ_LAT(1)) u_lat1 (
        .clk(clk), .reset(rst_n), .vblank_start(vblank), .clr_overrun(clr),
        .addr_B(addr_b[0]), .DataVideo(dv[0]), .snap_words(snap[0]),
        .snap_valid(sv[0]), .busy(busy[0]), .frame_done(fdone[0]), .overrun(ovr_o[0])
    );

    video_fetch_sched #(.NUM_WORDS(N), .READ_LAT(2)) u_lat2 (
        .clk(clk), .reset(rst_n), .vblank_start(vblank), .clr_overrun(clr),
        .addr_B(addr_b[1]), .DataVideo(dv[1]), .snap_words(snap[1]),
        .snap_valid(sv[1]), .busy(busy[1]), .frame_done(fdone[1]), .overrun(ovr_o[1])
    );

    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    bit            chk_en = 1'b0;
    logic [31:0]   mem  [N];
    logic [31:0]   hist [2][2];
    logic [31:0]   pend [2];
    bit            act  [2];
    int            s_cyc [2];
    bit            ovr_m [2];
    logic [31:0]   wexp [2][N];
    logic [SW-1:0] ref_snap [2];
    bit            ref_sv [2];
    exp_t          sbq [2][$];

    task automatic chk(input string name, input int lane, input logic [SW-1:0] got,
                       input logic [SW-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s lane%0d cyc=%0d got=%h want=%h", name, lane, cyc, got, want);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] d;
        d = 32'hDEAD_BEEF;
        for (int k = 0; k < N; k++) if (a == TB_ADDR[k]) d = mem[k];
        return d;
    endfunction

    // Reference for one lane in the current cycle: check outputs, then apply this cycle's inputs.
    task automatic model_step(input int l);
        int            lat, off;
        bit            busy_now;
        logic [31:0]   ea;
        logic [SW-1:0] w;
        lat = l + 1;
        off = cyc - s_cyc[l];
        pend[l] = mem_rd(addr_b[l]);
        if (chk_en) begin
            ea = TB_ADDR[0];
            if (act[l]) begin
                ea = TB_ADDR[N-1];
                for (int k = 0; k < N; k++) if (k == off - 1) ea = TB_ADDR[k];
            end
            chk("addr_B", l, SW'(addr_b[l]), SW'(ea));
            chk("busy", l, SW'(busy[l]), SW'(act[l]));
            chk("overrun", l, SW'(ovr_o[l]), SW'(ovr_m[l]));
        end
        if (act[l]) for (int k = 0; k < N; k++) if (k == off - 1) wexp[l][k] = mem[k];
        busy_now = act[l];
        if (!rst_n) begin
            act[l]      = 1'b0;
            ovr_m[l]    = 1'b0;
            ref_snap[l] = '0;
            ref_sv[l]   = 1'b0;
            sbq[l].delete();
        end else begin
            if (vblank && busy_now) ovr_m[l] = 1'b1;
            else if (clr)           ovr_m[l] = 1'b0;
            if (busy_now && off == N + lat + 1) begin
                for (int k = 0; k < N; k++) w[k*32 +: 32] = wexp[l][k];
                sbq[l].push_back('{words: w, due: cyc + 1});
                act[l] = 1'b0;
            end
            if (vblank && !busy_now) begin
                act[l]   = 1'b1;
                s_cyc[l] = cyc;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        for (int l = 0; l < 2; l++) model_step(l);
        if (!rst_n) chk_en = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        for (int l = 0; l < 2; l++) begin
            hist[l][1] = hist[l][0];
            hist[l][0] = pend[l];
        end
        dv[0] = hist[0][0];
        dv[1] = hist[1][1];
    endtask

    task automatic drive(input bit v, input bit c, input bit r);
        vblank = v;
        clr    = c;
        rst_n  = r;
        tick();
    endtask

    // Scoreboard monitor: every frame_done must match the oldest expected commit.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            for (int l = 0; l < 2; l++) begin
                if (fdone[l] === 1'b1) begin
                    if (sbq[l].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL frame_done_unexpected lane%0d cyc=%0d got=1 want=0", l, cyc);
                    end else begin
                        e = sbq[l].pop_front();
                        chk("frame_done_cycle", l, SW'(cyc), SW'(e.due));
                        chk("snap_words", l, snap[l], e.words);
                        ref_snap[l] = e.words;
                        ref_sv[l]   = 1'b1;
                    end
                end else begin
                    if (sbq[l].size() != 0 && sbq[l][0].due <= cyc) begin
                        e = sbq[l].pop_front();
                        n_tests++;
                        n_fail++;
                        $display("FAIL frame_done_missing lane%0d cyc=%0d got=0 want=1 due=%0d",
                                 l, cyc, e.due);
                    end
                    chk("snap_stable", l, snap[l], ref_snap[l]);
                end
                chk("snap_valid", l, SW'(sv[l]), SW'(ref_sv[l]));
            end
        end
    end

    initial begin
        vblank = 1'b0;
        clr    = 1'b0;
        rst_n  = 1'b0;
        for (int l = 0; l < 2; l++) begin
            dv[l] = '0; pend[l] = '0; hist[l][0] = '0; hist[l][1] = '0;
            act[l] = 1'b0; s_cyc[l] = 0; ovr_m[l] = 1'b0; ref_snap[l] = '0; ref_sv[l] = 1'b0;
            for (int k = 0; k < N; k++) wexp[l][k] = '0;
        end
        for (int k = 0; k < N; k++) mem[k] = 32'h11 * (k + 1);

        repeat (3) drive(0, 0, 0);
        // Basic frame, vblank in the very first cycle after reset release.
        drive(1, 0, 1);
        repeat (12) drive(0, 0, 1);

        // Overrun: second vblank at t+3, then clear-with-set, then clear alone.
        drive(1, 0, 1);
        repeat (2) drive(0, 0, 1);
        drive(1, 0, 1);
        repeat (2) drive(0, 0, 1);
        drive(1, 1, 1);
        repeat (8) drive(0, 0, 1);
        drive(0, 1, 1);
        drive(0, 0, 1);

        // Memory rewritten after word 2 has been read.
        drive(1, 0, 1);
        repeat (3) drive(0, 0, 1);
        for (int k = 0; k < N; k++) mem[k] = 32'hAA + k;
        repeat (10) drive(0, 0, 1);

        // Reset in the middle of ISSUE.
        drive(1, 0, 1);
        repeat (3) drive(0, 0, 1);
        drive(0, 0, 0);
        repeat (4) drive(0, 0, 1);

        repeat (400) begin
            if ($urandom_range(3) == 0) begin
                int wi;
                wi = int'($urandom_range(N - 1));
                for (int k = 0; k < N; k++) if (k == wi) mem[k] = $urandom;
            end
            drive($urandom_range(7) == 0, $urandom_range(15) == 0, $urandom_range(99) != 0);
        end
        repeat (15) drive(0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
